// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the register file with busy-bit scoreboard.
//   master: the pipeline side (decode + writeback) driving addresses, data and issue requests.
//   slave : the register file itself.
// Signals:
//   we, A3, WD, BE          writeback port (byte-lane enables in BE)
//   A1, A2 / RD1, RD2       two combinational read ports
//   iss_valid, iss_rd,
//   iss_wr, iss_use1/2      issue request from decode
//   stall                   combinational issue block
//   busy, busy_cnt          registered scoreboard state
// Issue handshake: iss_valid is the valid and ~stall is the ready. An instruction
// transfers on a rising edge where iss_valid=1 and stall=0. stall is a combinational
// function of the current iss_* / A1 / A2 / we / A3 inputs and the registered busy bits,
// so decode must look at it in the same cycle it presents the instruction.
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic              we;
  logic [AW-1:0]     A3;
  logic [XLEN-1:0]   WD;
  logic [XLEN/8-1:0] BE;
  logic [AW-1:0]     A1;
  logic [AW-1:0]     A2;
  logic [XLEN-1:0]   RD1;
  logic [XLEN-1:0]   RD2;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              iss_wr;
  logic              iss_use1;
  logic              iss_use2;
  logic              stall;
  logic [NREG-1:0]   busy;
  logic [AW:0]       busy_cnt;

  modport master (
    output we, A3, WD, BE, A1, A2, iss_valid, iss_rd, iss_wr, iss_use1, iss_use2,
    input  RD1, RD2, stall, busy, busy_cnt
  );

  modport slave (
    input  we, A3, WD, BE, A1, A2, iss_valid, iss_rd, iss_wr, iss_use1, iss_use2,
    output RD1, RD2, stall, busy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 1-write / 2-read register file with byte enables,
// write-to-read bypass, optional hardwired zero register and a busy-bit scoreboard
// that stalls issue on RAW and WAW hazards against in-flight writebacks.
// Ports:
//   clk  rising-edge clock
//   res  asynchronous active-low reset
//   bus  reg_file_sb_if.slave (writeback, read, issue and scoreboard signals)
// Parameters:
//   XLEN     register width (multiple of 8)
//   NREG     number of registers (power of 2, >= 2)
//   ZERO_REG 1: register 0 reads 0, ignores writes, is never busy
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          res,
  reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q, busy_next;
  logic [AW:0]     cnt_q, cnt_next;

  logic [XLEN-1:0] wr_merged;
  logic            wr_ok;
  logic [NREG-1:0] clr_vec, set_vec;
  logic            raw1, raw2, waw, accept;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Byte-lane merge of the writeback data onto the current register contents.
  // The same value feeds storage and the bypass path, so they cannot disagree.
  always_comb begin
    wr_merged = regs[bus.A3];
    for (int i = 0; i < NB; i++) begin
      if (bus.BE[i]) wr_merged[8*i +: 8] = bus.WD[8*i +: 8];
    end
  end

  assign wr_ok = bus.we && !is_zero(bus.A3);

  // Storage
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.A3] <= wr_merged;
    end
  end

  // Read ports with bypass; forced to 0 while reset is held
  always_comb begin
    bus.RD1 = '0;
    if (res && !is_zero(bus.A1)) begin
      if (wr_ok && (bus.A3 == bus.A1)) bus.RD1 = wr_merged;
      else                             bus.RD1 = regs[bus.A1];
    end
  end

  always_comb begin
    bus.RD2 = '0;
    if (res && !is_zero(bus.A2)) begin
      if (wr_ok && (bus.A3 == bus.A2)) bus.RD2 = wr_merged;
      else                             bus.RD2 = regs[bus.A2];
    end
  end

  // Hazards. A writeback landing this cycle resolves the hazard because the
  // bypass already delivers its value and its busy bit clears at this edge.
  always_comb begin
    raw1 = bus.iss_use1 && busy_q[bus.A1]     && !(bus.we && (bus.A3 == bus.A1));
    raw2 = bus.iss_use2 && busy_q[bus.A2]     && !(bus.we && (bus.A3 == bus.A2));
    waw  = bus.iss_wr   && busy_q[bus.iss_rd] && !(bus.we && (bus.A3 == bus.iss_rd));
  end

  assign bus.stall = res && bus.iss_valid && (raw1 || raw2 || waw);
  assign accept    = bus.iss_valid && !bus.stall;

  // Scoreboard next state: clear from writeback first, then set from issue,
  // so a same-cycle set and clear of one register leaves it busy.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (bus.we) clr_vec[bus.A3] = 1'b1;
    if (accept && bus.iss_wr && !is_zero(bus.iss_rd)) set_vec[bus.iss_rd] = 1'b1;
    busy_next = (busy_q & ~clr_vec) | set_vec;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < NREG; i++) cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_next;
      cnt_q  <= cnt_next;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int W    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic pop(input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      check("sb_empty", W'(exp_q.size()), 64'd1);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.we = 1'b0; bus.A3 = '0; bus.WD = '0; bus.BE = '0;
    bus.A1 = '0; bus.A2 = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.iss_wr = 1'b0;
    bus.iss_use1 = 1'b0; bus.iss_use2 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic [3:0] be);
    bus.we = 1'b1; bus.A3 = a; bus.WD = d; bus.BE = be;
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic w);
    bus.iss_valid = 1'b1; bus.iss_rd = rd; bus.iss_wr = w;
  endtask

  // ---------------- reference model for random phase ----------------
  logic [XLEN-1:0] mdl [NREG];
  logic [NREG-1:0] mbusy;

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] o, input logic [XLEN-1:0] d,
                                            input logic [3:0] be);
    logic [XLEN-1:0] m;
    m = o;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (bus.we && bus.A3 == a) return merge(mdl[a], bus.WD, bus.BE);
    return mdl[a];
  endfunction

  function automatic logic clr(input logic [AW-1:0] r);
    return bus.we && (bus.A3 == r);
  endfunction

  // ---------------- stimulus ----------------
  logic exp_stall;

  initial begin
    res = 1'b0;
    idle();
    #1;
    // Reset held: outputs quiet even with an issue request presented
    bus.A1 = 5'd5; issue(5'd7, 1'b1); bus.iss_use1 = 1'b1;
    #1;
    push("rst_rd1", 0);   pop(W'(bus.RD1));
    push("rst_stall", 0); pop(W'(bus.stall));
    repeat (2) tick();
    push("rst_busy_held", 0); pop(W'(bus.busy));
    idle();
    res = 1'b1;
    bus.A1 = 5'd5; bus.A2 = 5'd0;
    #1;
    push("rel_rd1", 0);   pop(W'(bus.RD1));
    push("rel_rd2", 0);   pop(W'(bus.RD2));
    push("rel_busy", 0);  pop(W'(bus.busy));
    push("rel_cnt", 0);   pop(W'(bus.busy_cnt));
    push("rel_stall", 0); pop(W'(bus.stall));

    // Write and bypass
    wr(5'd5, 32'd42, 4'hF); bus.A1 = 5'd5;
    #1; push("byp_rd1", 42); pop(W'(bus.RD1));
    tick(); idle(); bus.A1 = 5'd5;
    #1; push("store_rd1", 42); pop(W'(bus.RD1));
    wr(5'd0, 32'd99, 4'hF); bus.A2 = 5'd0;
    #1; push("zero_byp_rd2", 0); pop(W'(bus.RD2));
    tick(); idle(); bus.A2 = 5'd0;
    #1; push("zero_rd2", 0); pop(W'(bus.RD2));

    // Byte enables
    wr(5'd10, 32'h11223344, 4'hF);
    tick(); idle();
    wr(5'd10, 32'hAABBCCDD, 4'b0101); bus.A1 = 5'd10;
    #1; push("be_byp", 32'h11BB33DD); pop(W'(bus.RD1));
    tick(); idle(); bus.A2 = 5'd10;
    #1; push("be_store", 32'h11BB33DD); pop(W'(bus.RD2));
    // BE=0 write leaves data intact
    wr(5'd10, 32'hFFFFFFFF, 4'h0); bus.A1 = 5'd10;
    #1; push("be0_byp", 32'h11BB33DD); pop(W'(bus.RD1));
    tick(); idle();

    // RAW stall and release
    issue(5'd7, 1'b1);
    #1; push("raw_iss_stall", 0); pop(W'(bus.stall));
    tick(); idle();
    push("raw_busy", 64'h80); pop(W'(bus.busy));
    push("raw_cnt", 1);       pop(W'(bus.busy_cnt));
    issue(5'd9, 1'b0); bus.iss_use1 = 1'b1; bus.A1 = 5'd7;
    #1; push("raw_stall", 1); pop(W'(bus.stall));
    tick();
    push("raw_hold_busy", 64'h80); pop(W'(bus.busy));
    wr(5'd7, 32'd5, 4'hF);
    #1; push("raw_rel_stall", 0); pop(W'(bus.stall));
    push("raw_rel_rd1", 5);       pop(W'(bus.RD1));
    tick(); idle();
    push("raw_clr_busy", 0); pop(W'(bus.busy));
    push("raw_clr_cnt", 0);  pop(W'(bus.busy_cnt));

    // WAW and simultaneous set/clear
    issue(5'd3, 1'b1);
    tick(); idle();
    push("waw_busy", 64'h8); pop(W'(bus.busy));
    issue(5'd3, 1'b1); wr(5'd3, 32'd1, 4'hF);
    #1; push("waw_setclr_stall", 0); pop(W'(bus.stall));
    tick(); idle();
    push("waw_setclr_busy", 64'h8); pop(W'(bus.busy));
    push("waw_setclr_cnt", 1);      pop(W'(bus.busy_cnt));
    issue(5'd3, 1'b1);
    #1; push("waw_stall", 1); pop(W'(bus.stall));
    tick(); idle();
    wr(5'd3, 32'd2, 4'hF);
    tick(); idle();
    push("waw_clr_busy", 0); pop(W'(bus.busy));
    // Issue to the zero register never marks it busy
    issue(5'd0, 1'b1);
    tick(); idle();
    push("zero_not_busy", 0); pop(W'(bus.busy_cnt));

    // Async reset mid-operation
    wr(5'd9, 32'hDEADBEEF, 4'hF); issue(5'd1, 1'b1);
    tick(); idle(); issue(5'd2, 1'b1);
    tick(); idle(); issue(5'd4, 1'b1);
    tick(); idle();
    push("pre_rst_busy", 64'h16); pop(W'(bus.busy));
    push("pre_rst_cnt", 3);       pop(W'(bus.busy_cnt));
    bus.A1 = 5'd9;
    #1; push("pre_rst_rd1", 32'hDEADBEEF); pop(W'(bus.RD1));
    res = 1'b0;
    #1;
    push("async_busy", 0); pop(W'(bus.busy));
    push("async_cnt", 0);  pop(W'(bus.busy_cnt));
    push("async_rd1", 0);  pop(W'(bus.RD1));
    tick();
    res = 1'b1;
    #1; push("post_rst_rd1", 0); pop(W'(bus.RD1));
    tick(); idle();

    // Random phase against the reference model
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
    mbusy = '0;
    for (int k = 0; k < 9; k++) begin
      wr(AW'(k + 16), 32'h0, 4'hF);
      tick();
    end
    idle();
    for (int n = 0; n < 400; n++) begin
      bus.we   = 1'($urandom_range(0, 1));
      bus.A3   = AW'($urandom_range(0, 7));
      bus.WD   = $urandom;
      bus.BE   = 4'($urandom_range(0, 15));
      bus.A1   = AW'($urandom_range(0, 7));
      bus.A2   = AW'($urandom_range(0, 7));
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = AW'($urandom_range(0, 7));
      bus.iss_wr    = 1'($urandom_range(0, 1));
      bus.iss_use1  = 1'($urandom_range(0, 1));
      bus.iss_use2  = 1'($urandom_range(0, 1));
      #1;
      exp_stall = bus.iss_valid &&
                  ((bus.iss_use1 && mbusy[bus.A1] && !clr(bus.A1)) ||
                   (bus.iss_use2 && mbusy[bus.A2] && !clr(bus.A2)) ||
                   (bus.iss_wr && mbusy[bus.iss_rd] && !clr(bus.iss_rd)));
      push("rnd_rd1", W'(exp_rd(bus.A1)));
      push("rnd_rd2", W'(exp_rd(bus.A2)));
      push("rnd_stall", W'(exp_stall));
      pop(W'(bus.RD1));
      pop(W'(bus.RD2));
      pop(W'(bus.stall));
      if (bus.we && bus.A3 != '0) mdl[bus.A3] = merge(mdl[bus.A3], bus.WD, bus.BE);
      if (bus.we) mbusy[bus.A3] = 1'b0;
      if (bus.iss_valid && !exp_stall && bus.iss_wr && bus.iss_rd != '0) mbusy[bus.iss_rd] = 1'b1;
      tick();
      push("rnd_busy", W'(mbusy));
      push("rnd_cnt", W'($countones(mbusy)));
      pop(W'(bus.busy));
      pop(W'(bus.busy_cnt));
    end

    check("sb_drained", W'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the single-write, dual-read CPU register file. It adds configurable width and depth, per-byte write enables, a write-to-read bypass, an optional hardwired zero register and an integrated busy-bit scoreboard. Decode uses the scoreboard to stall issue on RAW and WAW hazards against in-flight writebacks. It sits between decode (read and issue ports) and writeback (write port) in the CPU pipeline.

## Interface
Parameters:
- XLEN, 32, register width in bits; must be a multiple of 8.
- NREG, 32, number of registers; must be a power of 2 and at least 2.
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never marked busy.
- AW (localparam), $clog2(NREG), register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  reset, asynchronous, active-low.
- we  in  1  writeback write enable.
- A3  in  AW  writeback destination address.
- WD  in  XLEN  writeback data.
- BE  in  XLEN/8  byte-lane write enables; bit i covers WD[8i+7:8i].
- A1  in  AW  read port 1 address.
- A2  in  AW  read port 2 address.
- RD1  out  XLEN  read port 1 data, combinational.
- RD2  out  XLEN  read port 2 data, combinational.
- iss_valid  in  1  decode is presenting an instruction for issue.
- iss_rd  in  AW  issuing instruction's destination register.
- iss_wr  in  1  issuing instruction writes iss_rd.
- iss_use1  in  1  issuing instruction reads A1.
- iss_use2  in  1  issuing instruction reads A2.
- stall  out  1  issue blocked this cycle; combinational.
- busy  out  NREG  registered busy-bit vector.
- busy_cnt  out  AW+1  registered count of set busy bits.

## Operation
- Reset (res=0, asynchronous):
  - All registers are cleared to 0, busy is 0 and busy_cnt is 0.
  - While reset is held, RD1, RD2 and stall are 0.
  - Assertion mid-operation discards pending writes and the scoreboard immediately.
- Write:
  - On a clock edge with we=1, each lane with BE[i]=1 takes WD; other lanes keep their value.
  - A3=0 with ZERO_REG=1 is ignored.
  - BE=0 with we=1 changes no data but still clears busy[A3].
- Read:
  - RDn = reg[An], except when we=1 and A3==An (and not the zero register). In that case RDn is the byte-merged value that will be written (bypass).
  - An=0 with ZERO_REG=1 always returns 0.
- Hazard detection, combinational. Let clr(r) = we & (A3==r). Then stall = iss_valid & (raw1 | raw2 | waw):
  - raw1 = iss_use1 & busy[A1] & ~clr(A1)
  - raw2 = iss_use2 & busy[A2] & ~clr(A2)
  - waw = iss_wr & busy[iss_rd] & ~clr(iss_rd)
- Issue: the instruction is accepted when iss_valid=1 and stall=0. If iss_wr=1 and iss_rd is not the zero register, busy[iss_rd] is set at that edge.
- Busy update per edge:
  - The clear from we applies first, then the set from issue. A set and a clear of the same register in the same cycle leaves it busy (the new producer wins).
  - A clear of a non-busy register is harmless.
- busy_cnt always equals popcount(busy). It is updated in the same edge as busy, ranges 0..NREG (or NREG-1 with ZERO_REG=1), and never wraps.

## Timing
- Write latency: 1 edge. Data is visible through bypass in the same cycle and from storage from the next cycle.
- busy and busy_cnt change only on the clock edge or on reset.
- stall has zero latency from its inputs. It is not registered, so decode must sample it in the same cycle.
- Throughput: one write and one issue per cycle, with no bubbles.
- Reset release: the first edge with res=1 performs normal operation.

## Test plan
- Reset then read: hold res=0 for 2 cycles, release, A1=5, A2=0 -> RD1=0, RD2=0, busy=0, busy_cnt=0, stall=0.
- Write and bypass: we=1, A3=5, WD=42, BE=4'hF, A1=5 -> RD1=42 in the same cycle. Next cycle with we=0 -> RD1=42. A3=0, WD=99, then A2=0 -> RD2=0.
- Byte enables: reg10 = 32'h11223344, then we=1, A3=10, WD=32'hAABBCCDD, BE=4'b0101 -> RD of reg10 becomes 32'h11BB33DD.
- RAW stall and release:
  - Issue iss_rd=7, iss_wr=1 -> busy[7]=1, busy_cnt=1.
  - Next, iss_use1=1, A1=7 -> stall=1.
  - Writeback we=1, A3=7, WD=5 in the same cycle -> stall=0, RD1=5, busy[7]=0 next.
- WAW and simultaneous set/clear:
  - Busy reg 3, then issue iss_rd=3 with we=1, A3=3 -> stall=0, busy[3] stays 1, busy_cnt unchanged.
  - Issue iss_rd=3 with no writeback -> stall=1.
- Async reset mid-operation: busy = regs 1, 2 and 4 (busy_cnt=3), drop res between edges -> busy=0, busy_cnt=0 and registers 0 immediately, without waiting for a clock edge.
